// File: rtl/axi_rd_arbiter.sv
// axi_rd_arbiter: shares one AXI read channel (AR + R) between the icache and
// dcache controllers, with a single outstanding read at a time.
// Optional feature macro: AXI_RD_ARB_RR_EN selects round-robin arbitration on
// simultaneous requests; when undefined, dcache always wins a tie.
module axi_rd_arbiter #(
    parameter logic [3:0] I_ARID  = 4'd0,
    parameter logic [3:0] D_ARID  = 4'd1,
    parameter logic [2:0] AR_SIZE = 3'b010
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_r_req,
    input  logic [31:0] i_r_addr,
    input  logic [7:0]  i_r_length,
    input  logic        i_r_data_ready,
    output logic        i_r_rdy,
    output logic        i_ret_valid,
    output logic        i_ret_last,
    output logic [31:0] i_r_data,
    input  logic        d_r_req,
    input  logic [31:0] d_r_addr,
    input  logic [7:0]  d_r_length,
    input  logic        d_r_data_ready,
    output logic        d_r_rdy,
    output logic        d_ret_valid,
    output logic        d_ret_last,
    output logic [31:0] d_r_data,
    output logic        arvalid,
    input  logic        arready,
    output logic [31:0] araddr,
    output logic [7:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic [3:0]  arid,
    input  logic        rvalid,
    output logic        rready,
    input  logic [31:0] rdata,
    input  logic        rlast,
    input  logic [3:0]  rid,
    output logic        rd_err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_AR,
        S_DATA
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic        owner_d;
    logic [31:0] addr_q;
    logic [7:0]  len_q;
    logic [7:0]  beat_cnt;
    logic        grant_d;
    logic        any_req;
    logic        beat;
    logic        owner_rdy;
    logic [3:0]  owner_id;

    assign any_req  = i_r_req | d_r_req;
    assign owner_id = owner_d ? D_ARID : I_ARID;
    assign arsize   = AR_SIZE;
    assign arburst  = 2'b01;

`ifdef AXI_RD_ARB_RR_EN
    logic last_d;

    // Tie goes to whichever requester did not win the previous grant
    always_comb begin
        grant_d = d_r_req & (~i_r_req | ~last_d);
    end

    // Remember who was granted last; dcache at reset so icache wins the first tie
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            last_d <= 1'b1;
        else if (state == S_IDLE && any_req)
            last_d <= grant_d;
    end
`else
    assign grant_d = d_r_req;
`endif

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    // Next state plus the AR/R handshakes and beat forwarding to the owner
    always_comb begin
        state_nxt   = state;
        arvalid     = 1'b0;
        araddr      = '0;
        arlen       = '0;
        arid        = '0;
        rready      = 1'b0;
        i_r_rdy     = 1'b0;
        d_r_rdy     = 1'b0;
        i_ret_valid = 1'b0;
        i_ret_last  = 1'b0;
        i_r_data    = '0;
        d_ret_valid = 1'b0;
        d_ret_last  = 1'b0;
        d_r_data    = '0;
        beat        = 1'b0;
        owner_rdy   = owner_d ? d_r_data_ready : i_r_data_ready;
        case (state)
            S_IDLE: begin
                if (any_req)
                    state_nxt = S_AR;
            end
            S_AR: begin
                arvalid = 1'b1;
                araddr  = addr_q;
                arlen   = len_q;
                arid    = owner_id;
                if (arready) begin
                    i_r_rdy   = ~owner_d;
                    d_r_rdy   = owner_d;
                    state_nxt = S_DATA;
                end
            end
            S_DATA: begin
                rready = owner_rdy;
                beat   = rvalid & owner_rdy;
                if (owner_d) begin
                    d_ret_valid = beat;
                    d_ret_last  = beat & rlast;
                    d_r_data    = rdata;
                end else begin
                    i_ret_valid = beat;
                    i_ret_last  = beat & rlast;
                    i_r_data    = rdata;
                end
                if (beat && rlast)
                    state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Latch the winner's request at grant time and count accepted beats
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner_d  <= 1'b0;
            addr_q   <= '0;
            len_q    <= '0;
            beat_cnt <= '0;
        end else if (state == S_IDLE && any_req) begin
            owner_d  <= grant_d;
            addr_q   <= grant_d ? d_r_addr : i_r_addr;
            len_q    <= grant_d ? d_r_length : i_r_length;
            beat_cnt <= '0;
        end else if (beat) begin
            beat_cnt <= beat_cnt + 8'd1;
        end
    end

    // Sticky flag for bursts whose length or ID disagree with the request
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            rd_err <= 1'b0;
        else if (beat && ((rlast && beat_cnt != len_q) ||
                          (!rlast && beat_cnt == len_q) ||
                          (rid != owner_id)))
            rd_err <= 1'b1;
    end

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// tb_axi_rd_arbiter: randomized self-checking bench for axi_rd_arbiter.
// Honours AXI_RD_ARB_RR_EN so the arbitration model matches the build.
module tb_axi_rd_arbiter;

    localparam logic [3:0] I_ID = 4'd0;
    localparam logic [3:0] D_ID = 4'd1;
`ifdef AXI_RD_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        i_r_req, i_r_data_ready, i_r_rdy, i_ret_valid, i_ret_last;
    logic [31:0] i_r_addr, i_r_data;
    logic [7:0]  i_r_length;
    logic        d_r_req, d_r_data_ready, d_r_rdy, d_ret_valid, d_ret_last;
    logic [31:0] d_r_addr, d_r_data;
    logic [7:0]  d_r_length;
    logic        arvalid, arready, rvalid, rready, rlast, rd_err;
    logic [31:0] araddr, rdata;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic [3:0]  arid, rid;

    int tests = 0;
    int failed = 0;

    // Reference model state: who won the previous grant (dcache after reset)
    bit model_last_d = 1'b1;

    // Observations gathered while driving one grant
    logic [31:0] i_got_q[$], d_got_q[$], exp_q[$];
    bit          i_last_q[$], d_last_q[$];
    int          i_rdy_cnt, d_rdy_cnt, rready_bad, obs_early_rready, obs_stall, obs_wait;
    bit          obs_timeout, obs_unstable;
    logic [3:0]  obs_id;
    logic [31:0] obs_addr;
    logic [7:0]  obs_len;
    logic [2:0]  obs_size;
    logic [1:0]  obs_burst;

    axi_rd_arbiter dut (
        .clk(clk), .rst(rst),
        .i_r_req(i_r_req), .i_r_addr(i_r_addr), .i_r_length(i_r_length),
        .i_r_data_ready(i_r_data_ready), .i_r_rdy(i_r_rdy), .i_ret_valid(i_ret_valid),
        .i_ret_last(i_ret_last), .i_r_data(i_r_data),
        .d_r_req(d_r_req), .d_r_addr(d_r_addr), .d_r_length(d_r_length),
        .d_r_data_ready(d_r_data_ready), .d_r_rdy(d_r_rdy), .d_ret_valid(d_ret_valid),
        .d_ret_last(d_ret_last), .d_r_data(d_r_data),
        .arvalid(arvalid), .arready(arready), .araddr(araddr), .arlen(arlen),
        .arsize(arsize), .arburst(arburst), .arid(arid),
        .rvalid(rvalid), .rready(rready), .rdata(rdata), .rlast(rlast), .rid(rid),
        .rd_err(rd_err)
    );

    always #5 clk = ~clk;

    // Spec arbitration rule: single requester wins; ties by priority policy
    function automatic bit model_pick_d(input bit ri, input bit rd);
        if (rd && !ri) return 1'b1;
        if (ri && !rd) return 1'b0;
        return RR ? !model_last_d : 1'b1;
    endfunction

    // Mid-cycle sample point: also records every handshake and delivered beat
    task automatic at_neg();
        @(negedge clk);
        if (i_r_rdy === 1'b1) i_rdy_cnt++;
        if (d_r_rdy === 1'b1) d_rdy_cnt++;
        if (i_ret_valid === 1'b1) begin i_got_q.push_back(i_r_data); i_last_q.push_back(i_ret_last); end
        if (d_ret_valid === 1'b1) begin d_got_q.push_back(d_r_data); d_last_q.push_back(d_ret_last); end
    endtask

    task automatic to_pos();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_obs();
        i_got_q.delete(); d_got_q.delete(); exp_q.delete();
        i_last_q.delete(); d_last_q.delete();
        i_rdy_cnt = 0; d_rdy_cnt = 0; rready_bad = 0; obs_early_rready = 0;
        obs_stall = 0; obs_wait = -1; obs_timeout = 1'b0; obs_unstable = 1'b0;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        i_r_req = 0; i_r_addr = 0; i_r_length = 0; i_r_data_ready = 0;
        d_r_req = 0; d_r_addr = 0; d_r_length = 0; d_r_data_ready = 0;
        arready = 0; rvalid = 0; rdata = 0; rlast = 0; rid = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_last_d = 1'b1;
    endtask

    // Bus side of an AR handshake; rvalid is held high meanwhile and must be ignored
    task automatic do_ar(input int delay);
        int   waited = 0;
        logic hs_i, hs_d;
        rvalid = 1'b1; rlast = 1'b1; rid = 4'hF; rdata = $urandom();
        at_neg();
        while (arvalid !== 1'b1 && waited < 20) begin
            if (rready !== 1'b0) obs_early_rready++;
            to_pos(); at_neg(); waited++;
        end
        obs_wait = waited;
        if (arvalid !== 1'b1) begin
            obs_timeout = 1'b1; rvalid = 0; rlast = 0; to_pos();
            return;
        end
        obs_id = arid; obs_addr = araddr; obs_len = arlen; obs_size = arsize; obs_burst = arburst;
        for (int k = 0; k < delay; k++) begin
            to_pos(); at_neg();
            if (rready !== 1'b0) obs_early_rready++;
            if (arvalid !== 1'b1 || araddr !== obs_addr || arlen !== obs_len || arid !== obs_id) obs_unstable = 1'b1;
        end
        to_pos();
        arready = 1'b1;
        at_neg();
        if (rready !== 1'b0) obs_early_rready++;
        if (arvalid !== 1'b1 || araddr !== obs_addr || arlen !== obs_len || arid !== obs_id) obs_unstable = 1'b1;
        hs_i = i_r_rdy; hs_d = d_r_rdy;
        to_pos();
        arready = 1'b0; rvalid = 1'b0; rlast = 1'b0;
        if (hs_i === 1'b1) i_r_req = 1'b0;
        if (hs_d === 1'b1) d_r_req = 1'b0;
    endtask

    // Bus side of the R channel: delivers n beats; expected beats go into exp_q
    task automatic serve_beats(input bit own_d, input int n, input logic [3:0] rid_v,
                               input bit gaps, input int hold, input bit fixed, input bit with_last);
        int   beats = 0;
        int   cycles = 0;
        logic rdyv;
        bit   took;
        rdata = fixed ? 32'hDEADBEEF : $urandom();
        rid = rid_v;
        while (beats < n && cycles < 400) begin
            rvalid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            rlast = with_last && (beats == n - 1);
            if (cycles < hold) rdyv = 1'b0;
            else rdyv = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (own_d) begin d_r_data_ready = rdyv; i_r_data_ready = 1'($urandom_range(0, 1)); end
            else begin i_r_data_ready = rdyv; d_r_data_ready = 1'($urandom_range(0, 1)); end
            at_neg();
            if (rready !== rdyv) rready_bad++;
            if (rvalid && rready === 1'b0) obs_stall++;
            took = rvalid && rdyv;
            if (took) begin exp_q.push_back(rdata); beats++; end
            to_pos();
            if (took) rdata = $urandom();
            cycles++;
        end
        rvalid = 1'b0; rlast = 1'b0;
        if (beats < n) obs_timeout = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        i_r_req = 1; d_r_req = 1; arready = 1; rvalid = 1; rlast = 1;
        i_r_data_ready = 1; d_r_data_ready = 1; rdata = 32'hA5A5A5A5; rid = 0;
        i_r_addr = 32'h1234_5678; d_r_addr = 32'h9ABC_DEF0; i_r_length = 8'd7; d_r_length = 8'd3;
        @(negedge clk);
        tests++;
        if ({arvalid, rready, i_r_rdy, d_r_rdy, i_ret_valid, d_ret_valid, i_ret_last, d_ret_last, rd_err} !== 9'b0) begin
            failed++; $display("[TB] FAIL reset_ctrl got=%b exp=0", {arvalid, rready, i_r_rdy, d_r_rdy, i_ret_valid, d_ret_valid, i_ret_last, d_ret_last, rd_err});
        end
        tests++;
        if ({i_r_data, d_r_data, araddr, arlen, arid} !== 108'b0) begin
            failed++; $display("[TB] FAIL reset_data got i=%h d=%h addr=%h len=%h id=%h exp=0", i_r_data, d_r_data, araddr, arlen, arid);
        end
        i_r_req = 0; d_r_req = 0; arready = 0;
        @(posedge clk); #1;
        rst = 1'b0;
        model_last_d = 1'b1;
        repeat (2) begin
            at_neg();
            tests++;
            if ({arvalid, rready, i_ret_valid, d_ret_valid, rd_err} !== 5'b0) begin
                failed++; $display("[TB] FAIL idle_ignores_r got=%b exp=0", {arvalid, rready, i_ret_valid, d_ret_valid, rd_err});
            end
            to_pos();
        end
        rvalid = 0; rlast = 0;
    endtask

    task automatic test_icache_only();
        apply_reset();
        clear_obs();
        i_r_addr = 32'h1C000040; i_r_length = 8'd15; i_r_req = 1'b1;
        do_ar(2);
        serve_beats(1'b0, 16, I_ID, 1'b1, 0, 1'b0, 1'b1);
        repeat (2) begin at_neg(); to_pos(); end
        tests++;
        if (obs_timeout || obs_wait != 1) begin failed++; $display("[TB] FAIL ic_latency got wait=%0d timeout=%0b exp wait=1", obs_wait, obs_timeout); end
        tests++;
        if ({obs_addr, obs_len, obs_id, obs_size, obs_burst} !== {32'h1C000040, 8'd15, I_ID, 3'b010, 2'b01}) begin
            failed++; $display("[TB] FAIL ic_ar got addr=%h len=%0d id=%0d size=%b burst=%b exp 1c000040/15/0/010/01", obs_addr, obs_len, obs_id, obs_size, obs_burst);
        end
        tests++;
        if (obs_unstable || obs_early_rready != 0) begin failed++; $display("[TB] FAIL ic_ar_stable got unstable=%0b early_rready=%0d exp 0/0", obs_unstable, obs_early_rready); end
        tests++;
        if (i_rdy_cnt != 1 || d_rdy_cnt != 0) begin failed++; $display("[TB] FAIL ic_rdy_pulse got i=%0d d=%0d exp i=1 d=0", i_rdy_cnt, d_rdy_cnt); end
        tests++;
        if (i_got_q.size() != 16 || d_got_q.size() != 0) begin failed++; $display("[TB] FAIL ic_beats got i=%0d d=%0d exp i=16 d=0", i_got_q.size(), d_got_q.size()); end
        for (int k = 0; k < i_got_q.size() && k < exp_q.size(); k++) begin
            tests++;
            if (i_got_q[k] !== exp_q[k] || i_last_q[k] !== (k == 15)) begin
                failed++; $display("[TB] FAIL ic_beat%0d got data=%h last=%0b exp data=%h last=%0b", k, i_got_q[k], i_last_q[k], exp_q[k], k == 15);
            end
        end
        tests++;
        if (rready_bad != 0 || rd_err !== 1'b0) begin failed++; $display("[TB] FAIL ic_rready got bad=%0d rd_err=%b exp 0/0", rready_bad, rd_err); end
    endtask

    // Priority/round-robin scenario and randomized traffic share this flow
    task automatic test_arbitration(input int rounds, input bit force_both);
        logic [31:0] got[$];
        bit          gl[$];
        bit          pend_i, pend_d, win_d;
        logic [31:0] exp_addr;
        logic [7:0]  exp_len;
        logic [3:0]  exp_id;
        int          pat;
        apply_reset();
        for (int r = 0; r < rounds; r++) begin
            pat = force_both ? 3 : int'($urandom_range(1, 3));
            pend_i = (pat & 1) != 0;
            pend_d = (pat & 2) != 0;
            i_r_addr = $urandom() & 32'hFFFF_FFFC; i_r_length = 8'($urandom_range(0, 5));
            d_r_addr = $urandom() & 32'hFFFF_FFFC; d_r_length = 8'($urandom_range(0, 5));
            i_r_req = pend_i; d_r_req = pend_d;
            while (pend_i || pend_d) begin
                win_d = model_pick_d(pend_i, pend_d);
                exp_addr = win_d ? d_r_addr : i_r_addr;
                exp_len = win_d ? d_r_length : i_r_length;
                exp_id = win_d ? D_ID : I_ID;
                clear_obs();
                do_ar(int'($urandom_range(0, 2)));
                model_last_d = win_d;
                if (win_d) pend_d = 1'b0; else pend_i = 1'b0;
                serve_beats(win_d, int'(exp_len) + 1, exp_id, 1'b1, 0, 1'b0, 1'b1);
                if (win_d) begin got = d_got_q; gl = d_last_q; end
                else begin got = i_got_q; gl = i_last_q; end
                tests++;
                if (obs_timeout || obs_wait != 1) begin failed++; $display("[TB] FAIL arb_latency r%0d got wait=%0d timeout=%0b exp wait=1", r, obs_wait, obs_timeout); end
                tests++;
                if ({obs_id, obs_addr, obs_len, obs_size, obs_burst} !== {exp_id, exp_addr, exp_len, 3'b010, 2'b01}) begin
                    failed++; $display("[TB] FAIL arb_grant r%0d got id=%0d addr=%h len=%0d exp id=%0d addr=%h len=%0d", r, obs_id, obs_addr, obs_len, exp_id, exp_addr, exp_len);
                end
                tests++;
                if (i_rdy_cnt != int'(!win_d) || d_rdy_cnt != int'(win_d)) begin
                    failed++; $display("[TB] FAIL arb_rdy r%0d got i=%0d d=%0d exp i=%0d d=%0d", r, i_rdy_cnt, d_rdy_cnt, !win_d, win_d);
                end
                tests++;
                if (got.size() != exp_q.size() || (i_got_q.size() + d_got_q.size()) != exp_q.size()) begin
                    failed++; $display("[TB] FAIL arb_beats r%0d got i=%0d d=%0d exp owner=%0d", r, i_got_q.size(), d_got_q.size(), exp_q.size());
                end
                for (int k = 0; k < got.size() && k < exp_q.size(); k++) begin
                    tests++;
                    if (got[k] !== exp_q[k] || gl[k] !== (k == exp_q.size() - 1)) begin
                        failed++; $display("[TB] FAIL arb_beat r%0d b%0d got data=%h last=%0b exp data=%h", r, k, got[k], gl[k], exp_q[k]);
                    end
                end
                tests++;
                if (rready_bad != 0 || obs_early_rready != 0 || obs_unstable || rd_err !== 1'b0) begin
                    failed++; $display("[TB] FAIL arb_proto r%0d got bad=%0d early=%0d unstable=%0b rd_err=%b exp 0", r, rready_bad, obs_early_rready, obs_unstable, rd_err);
                end
            end
            i_r_req = 0; d_r_req = 0;
        end
    endtask

    task automatic test_backpressure();
        apply_reset();
        clear_obs();
        d_r_addr = 32'hBFAF_8000; d_r_length = 8'd0; d_r_req = 1'b1;
        do_ar(1);
        serve_beats(1'b1, 1, D_ID, 1'b0, 3, 1'b1, 1'b1);
        tests++;
        if (obs_id !== D_ID || obs_len !== 8'd0 || obs_addr !== 32'hBFAF_8000) begin
            failed++; $display("[TB] FAIL bp_ar got id=%0d len=%0d addr=%h exp 1/0/bfaf8000", obs_id, obs_len, obs_addr);
        end
        tests++;
        if (rready_bad != 0 || obs_stall != 3) begin failed++; $display("[TB] FAIL bp_rready got bad=%0d stalls=%0d exp 0/3", rready_bad, obs_stall); end
        tests++;
        if (d_got_q.size() != 1 || i_got_q.size() != 0) begin failed++; $display("[TB] FAIL bp_beats got d=%0d i=%0d exp 1/0", d_got_q.size(), i_got_q.size()); end
        else begin
            tests++;
            if (d_got_q[0] !== 32'hDEADBEEF || d_last_q[0] !== 1'b1) begin
                failed++; $display("[TB] FAIL bp_data got %h last=%0b exp deadbeef last=1", d_got_q[0], d_last_q[0]);
            end
        end
        tests++;
        if (rd_err !== 1'b0) begin failed++; $display("[TB] FAIL bp_rd_err got %b exp 0", rd_err); end
    endtask

    task automatic test_error();
        // Early rlast: length 3 but burst ends after two beats
        apply_reset();
        clear_obs();
        i_r_addr = 32'h0000_1000; i_r_length = 8'd3; i_r_req = 1'b1;
        do_ar(0);
        tests++;
        if (rd_err !== 1'b0) begin failed++; $display("[TB] FAIL err_pre got %b exp 0", rd_err); end
        serve_beats(1'b0, 2, I_ID, 1'b0, 0, 1'b0, 1'b1);
        tests++;
        if (rd_err !== 1'b1 || i_got_q.size() != 2) begin failed++; $display("[TB] FAIL err_early_last got rd_err=%b beats=%0d exp 1/2", rd_err, i_got_q.size()); end
        clear_obs();
        d_r_addr = 32'h0000_2000; d_r_length = 8'd0; d_r_req = 1'b1;
        do_ar(1);
        serve_beats(1'b1, 1, D_ID, 1'b0, 0, 1'b0, 1'b1);
        tests++;
        if (obs_timeout || obs_wait != 1 || obs_id !== D_ID || d_got_q.size() != 1) begin
            failed++; $display("[TB] FAIL err_recover got wait=%0d id=%0d beats=%0d exp 1/1/1", obs_wait, obs_id, d_got_q.size());
        end
        tests++;
        if (rd_err !== 1'b1) begin failed++; $display("[TB] FAIL err_sticky got %b exp 1", rd_err); end
        // Missing rlast on the beat that should have been final
        apply_reset();
        clear_obs();
        d_r_addr = 32'h0000_3000; d_r_length = 8'd1; d_r_req = 1'b1;
        do_ar(0);
        serve_beats(1'b1, 2, D_ID, 1'b0, 0, 1'b0, 1'b0);
        tests++;
        if (rd_err !== 1'b1) begin failed++; $display("[TB] FAIL err_no_last got %b exp 1", rd_err); end
        serve_beats(1'b1, 1, D_ID, 1'b0, 0, 1'b0, 1'b1);
        // Wrong rid on an otherwise well-formed burst
        apply_reset();
        clear_obs();
        i_r_addr = 32'h0000_4000; i_r_length = 8'd2; i_r_req = 1'b1;
        do_ar(0);
        serve_beats(1'b0, 3, 4'h5, 1'b0, 0, 1'b0, 1'b1);
        tests++;
        if (rd_err !== 1'b1 || i_got_q.size() != 3) begin failed++; $display("[TB] FAIL err_rid got rd_err=%b beats=%0d exp 1/3", rd_err, i_got_q.size()); end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        clear_obs();
        i_r_addr = 32'h1C000100; i_r_length = 8'd15; i_r_req = 1'b1;
        do_ar(0);
        serve_beats(1'b0, 4, I_ID, 1'b0, 0, 1'b0, 1'b0);
        rvalid = 1'b1; rlast = 1'b0; rid = I_ID; i_r_data_ready = 1'b1; rdata = 32'h5555_AAAA;
        #1;
        tests++;
        if (i_ret_valid !== 1'b1) begin failed++; $display("[TB] FAIL mid_beat5 got %b exp 1", i_ret_valid); end
        rst = 1'b1;
        #1;
        tests++;
        if ({arvalid, rready, i_r_rdy, d_r_rdy, i_ret_valid, d_ret_valid, i_ret_last, d_ret_last, rd_err} !== 9'b0 ||
            {i_r_data, d_r_data, araddr, arlen, arid} !== 108'b0) begin
            failed++; $display("[TB] FAIL mid_reset got ctrl=%b idata=%h exp 0", {arvalid, rready, i_ret_valid, d_ret_valid, rd_err}, i_r_data);
        end
        @(posedge clk); #1;
        rst = 1'b0; rvalid = 1'b0; model_last_d = 1'b1;
        clear_obs();
        i_r_addr = 32'h1C000200; i_r_length = 8'd1; i_r_req = 1'b1;
        do_ar(0);
        serve_beats(1'b0, 2, I_ID, 1'b1, 0, 1'b0, 1'b1);
        tests++;
        if (obs_timeout || obs_wait != 1 || obs_addr !== 32'h1C000200 || obs_id !== I_ID) begin
            failed++; $display("[TB] FAIL mid_restart got wait=%0d addr=%h id=%0d exp 1/1c000200/0", obs_wait, obs_addr, obs_id);
        end
        tests++;
        if (i_got_q.size() != 2 || rd_err !== 1'b0) begin failed++; $display("[TB] FAIL mid_beats got beats=%0d rd_err=%b exp 2/0", i_got_q.size(), rd_err); end
        else begin
            tests++;
            if (i_got_q[0] !== exp_q[0] || i_got_q[1] !== exp_q[1]) begin
                failed++; $display("[TB] FAIL mid_data got %h %h exp %h %h", i_got_q[0], i_got_q[1], exp_q[0], exp_q[1]);
            end
        end
    endtask

    // Run every scenario in order, then report
    initial begin
        clear_obs();
        test_reset();
        test_icache_only();
        test_arbitration(3, 1'b1);
        test_backpressure();
        test_arbitration(12, 1'b0);
        test_error();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    // Hard stop if something stalls beyond every per-wait bound
    initial begin
        #500000;
        $display("[TB] FAIL watchdog got timeout exp completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
